// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Holds the FSM state encoding, the operand width and the counter width.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int DIV_WIDTH = 32;
   localparam int CNT_W     = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
// Ports: rem/quo/dvsr current state; rem_nx/quo_nx state after one step.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvsr,
   output logic [WIDTH:0]   rem_nx,
   output logic [WIDTH-1:0] quo_nx
);

   logic [WIDTH:0]   sh_rem;
   logic [WIDTH+1:0] trial;
   logic             fits;

   assign sh_rem = {rem[WIDTH-1:0], quo[WIDTH-1]};
   // One extra bit so the borrow shows up as the trial sign.
   assign trial  = {1'b0, sh_rem} - {2'b00, dvsr};
   assign fits   = ~trial[WIDTH+1];

   always_comb begin
      rem_nx = sh_rem;
      quo_nx = {quo[WIDTH-2:0], 1'b0};
      if (fits) begin
         rem_nx    = trial[WIDTH:0];
         quo_nx[0] = 1'b1;
      end
   end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider: quotient on lo, remainder on hi, div0 on b==0.
// Ports: clk, reset (async low), start, a, b -> busy, done, div0, hi, lo.
module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic             sq;
   logic             sr;

   logic [WIDTH:0]   rem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;

   // 0x80..0 negates to itself and is then read as unsigned.
   assign abs_a = a[WIDTH-1] ? -a : a;
   assign abs_b = b[WIDTH-1] ? -b : b;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem    (rem),
      .quo    (quo),
      .dvsr   (dvsr),
      .rem_nx (rem_nx),
      .quo_nx (quo_nx)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         dvsr  <= '0;
         sq    <= 1'b0;
         sr    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         div0  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         done <= 1'b0;
         div0 <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (b == '0) begin
                     done <= 1'b1;
                     div0 <= 1'b1;
                  end else begin
                     quo   <= abs_a;
                     dvsr  <= abs_b;
                     rem   <= '0;
                     sq    <= a[WIDTH-1] ^ b[WIDTH-1];
                     sr    <= a[WIDTH-1];
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               lo    <= sq ? -quo : quo;
               hi    <= sr ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed vector bench for div_unit: table of divides plus abort/ignore runs.
// Drives inputs 1 time unit after the rising edge and samples there too.
module tb_div_unit;

   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic         div0;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int tests;
   int fails;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         div0;
   } vec_t;

   vec_t vecs [12];

   div_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .div0  (div0),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one divide and wait (bounded) for done; returns edge count
   // after the accept edge and the number of sampled cycles busy was high.
   task automatic run_div(input logic [W-1:0] va, input logic [W-1:0] vb,
                          output int lat, output int bcnt);
      a     = va;
      b     = vb;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      lat   = 0;
      bcnt  = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat;
      int bcnt;
      int ndone;
      int first;
      tests = 0;
      fails = 0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      reset = 1'b0;

      vecs[0]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
      vecs[1]  = '{32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
      vecs[2]  = '{32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0};
      vecs[3]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
      vecs[4]  = '{32'd5, 32'd0, 32'd14, 32'd2, 1'b1};
      vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
      vecs[6]  = '{32'd7, 32'd1, 32'd7, 32'd0, 1'b0};
      vecs[7]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0};
      vecs[8]  = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
      vecs[9]  = '{32'hFFFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFF, 1'b0};
      vecs[10] = '{32'h7FFFFFFF, 32'h80000000, 32'd0, 32'h7FFFFFFF, 1'b0};
      vecs[11] = '{32'h80000000, 32'd2, 32'hC0000000, 32'd0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_div0", {31'd0, div0}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         run_div(vecs[i].a, vecs[i].b, lat, bcnt);
         check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
         check($sformatf("v%0d_lat", i), lat,
               vecs[i].div0 ? 32'd0 : 32'd33);
         check($sformatf("v%0d_busy", i), bcnt,
               vecs[i].div0 ? 32'd0 : 32'd33);
         check($sformatf("v%0d_div0", i), {31'd0, div0},
               {31'd0, vecs[i].div0});
         check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
         check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
         tick();
         check($sformatf("v%0d_done_off", i), {31'd0, done}, 32'd0);
         check($sformatf("v%0d_div0_off", i), {31'd0, div0}, 32'd0);
      end

      // Abort in the middle of CALC.
      a     = 32'd100;
      b     = 32'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      reset = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done) ndone++;
      end
      check("abort_no_done", ndone, 32'd0);

      // Accept one divide, then hammer start while it is running.
      a     = 32'd100;
      b     = 32'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      first = -1;
      for (int c = 1; c <= 70; c++) begin
         if (c >= 2 && c <= 30) begin
            start = c[0];
            a     = 32'd9;
            b     = 32'd4;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            ndone++;
            if (first < 0) first = c - 1;
            check("ign_lo", lo, 32'd14);
            check("ign_hi", hi, 32'd2);
         end
         tick();
      end
      check("ign_ndone", ndone, 32'd1);
      check("ign_lat", first, 32'd33);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Sequential signed 32-bit divider that answers divide requests from the multicycle control unit for the `div` instruction. It accepts a start pulse with dividend and divisor and runs a 32-iteration restoring division on magnitudes. It then applies MIPS sign rules and presents remainder on `hi` and quotient on `lo`, which feed the HI/LO registers. It signals completion with a one-cycle `done`, and flags divide-by-zero on `div0` for the exception path.

## Interface
- `WIDTH`, 32, operand and result width; the iteration count equals `WIDTH`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `a`  in  WIDTH  dividend, two's complement; captured when `start` is accepted.
- `b`  in  WIDTH  divisor, two's complement; captured when `start` is accepted.
- `busy`  out  1  high in CALC and FIX.
- `done`  out  1  registered, one-cycle completion pulse.
- `div0`  out  1  registered, one-cycle pulse, coincident with `done`, when the divisor is 0.
- `hi`  out  WIDTH  remainder of the last successful divide.
- `lo`  out  WIDTH  quotient of the last successful divide.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: iterates; occupies `WIDTH` cycles.
  - FIX: applies signs and writes outputs; occupies 1 cycle.
- IDLE with `start`=1 and `b`≠0:
  - capture |a| into the quotient shift register and |b| into the divisor register;
  - clear the remainder register (WIDTH+1 bits);
  - latch sign flags: `sq` = a[msb]^b[msb], `sr` = a[msb];
  - clear the iteration counter; go to CALC.
- IDLE with `start`=1 and `b`=0: no divide is performed.
  - `done`=1 and `div0`=1 on the next cycle.
  - `hi`/`lo` keep their previous values; the state stays IDLE.
- CALC step, one per cycle:
  - shift {rem, quo} left by 1;
  - trial = rem − divisor;
  - if trial ≥ 0: rem ← trial, quo[0] ← 1; otherwise quo[0] ← 0;
  - when the counter reaches `WIDTH`−1, go to FIX.
- FIX:
  - `lo` ← `sq` ? −quo : quo; `hi` ← `sr` ? −rem : rem;
  - `done` ← 1; go to IDLE.
- Sign rules: the quotient truncates toward zero; the remainder takes the dividend's sign.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- Overflow case 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0, with no flag.
- `start` in CALC or FIX is ignored; no queuing.
- `done` and `div0` are high for exactly one cycle and deassert automatically.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `div0`=0, `hi`=0, `lo`=0, all internal registers 0.
- Let E0 be the edge that accepts `start`:
  - CALC covers edges E1..E32; FIX is applied at E33;
  - `hi`/`lo` are valid and `done`=1 in the cycle after E33; `done` returns to 0 after E34.
  - Latency from the start edge to done: 33 cycles (`WIDTH`+1).
- `busy` is 1 from after E0 through E33, and is 0 in the cycle `done` is high.
- A new `start` is accepted in the same cycle `done` is high, because the state is already IDLE.
- Divide-by-zero latency is 1 cycle: `done`/`div0` are high in the cycle after E0.
- Reset asserted mid-operation aborts immediately:
  - all outputs return to their reset values;
  - no `done` is produced for the aborted request.
- Inputs `a`/`b` may change after E0 without effect.

## Structure
- Shared package `div_pkg` holds:
  - state enum: IDLE=2'd0, CALC=2'd1, FIX=2'd2;
  - `DIV_WIDTH`=32;
  - `CNT_W`=$clog2(DIV_WIDTH).
- One sub-module, `div_step`: combinational single iteration, {rem, quo, divisor} → {rem', quo'}. It is instantiated once and registered by the top.
- Negation and absolute value are inline two's-complement expressions; no extra module.

## Test plan
- a=100, b=7, start at E0 → `done` after E33, `lo`=14, `hi`=2, `div0`=0, `busy` high for exactly 33 cycles.
- a=−100 (0xFFFFFF9C), b=7 → `lo`=0xFFFFFFF2 (−14), `hi`=0xFFFFFFFE (−2).
- a=100, b=−7 → `lo`=−14, `hi`=2.
- Divide by zero:
  - first complete a=100, b=7;
  - then start with a=5, b=0 → `done`=`div0`=1 one cycle later;
  - `hi`=2 and `lo`=14 are unchanged.
- a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0; also a=7, b=1 → `lo`=7, `hi`=0.
- Abort and ignore:
  - reset low at cycle 10 of CALC → `busy`/`hi`/`lo` read 0 immediately and no `done` follows;
  - after release, a new `start` pulsed repeatedly during CALC is ignored, and exactly one `done` appears 33 cycles after the accepted start.
